// File: rtl/nec_ir_pkg.sv
// ---------------------------------------------------------------------------
// nec_ir_pkg
// Definitions shared by the NEC IR transmitter and receiver: the frame state
// encoding and the length, in 562.5 us units, of every frame segment.
// ---------------------------------------------------------------------------
package nec_ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        RPT_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    localparam logic [7:0] LEAD_MARK_U  = 8'd16;
    localparam logic [7:0] LEAD_SPACE_U = 8'd8;
    localparam logic [7:0] RPT_SPACE_U  = 8'd4;
    localparam logic [7:0] BIT_MARK_U   = 8'd1;
    localparam logic [7:0] ZERO_SPACE_U = 8'd1;
    localparam logic [7:0] ONE_SPACE_U  = 8'd3;
    localparam logic [7:0] STOP_U       = 8'd1;

    // Marks are the segments in which the LED is driven.
    function automatic logic is_mark(input state_t s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// ---------------------------------------------------------------------------
// nec_carrier_gen
// Carrier phase counter. One period is CLOCK_SPEED/CARRIER_HZ cycles, high for
// the first half (rounded down), low for the rest.
//   clkIN      in  system clock
//   resetIN    in  asynchronous active-high reset
//   clearIN    in  synchronous clear: the next cycle is phase 0
//   carrierOUT out carrier level for the cycle that follows the next clock
//                  edge, so the caller can register it alongside its state
// ---------------------------------------------------------------------------
module nec_carrier_gen #(
    parameter int CLOCK_SPEED = 50_000_000,
    parameter int CARRIER_HZ  = 38_000
) (
    input  logic clkIN,
    input  logic resetIN,
    input  logic clearIN,
    output logic carrierOUT
);

    localparam int CPER = CLOCK_SPEED / CARRIER_HZ;   // must be >= 2
    localparam int PW   = $clog2(CPER);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CPER - 1);
    localparam logic [PW-1:0] HALF       = PW'(CPER / 2);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;

    // NOTE: every signal written here gets a value before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        phase_nxt = '0;
        if (!clearIN && phase != PHASE_LAST) begin
            phase_nxt = phase + 1'b1;
        end
    end

    assign carrierOUT = (phase_nxt < HALF);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            phase <= '0;
        end else begin
            phase <= phase_nxt;
        end
    end

endmodule

// File: rtl/nec_ir_transmitter.sv
// ---------------------------------------------------------------------------
// nec_ir_transmitter
// Serialises a 32-bit NEC word (MSB first) or an NEC repeat code onto an IR
// LED drive pin, with an optional carrier on the marks.
//   clkIN     in  system clock
//   resetIN   in  asynchronous active-high reset; aborts any frame silently
//   startIN   in  strobe: send a full frame, dataIN captured with it
//   repeatIN  in  strobe: send a repeat code (startIN wins if both)
//   dataIN    in  [31:0] word to send, bit 31 first
//   busyOUT   out frame in progress, including the trailing gap
//   doneOUT   out one-cycle pulse on return to IDLE
//   txOUT     out registered LED drive, active high
// A strobe accepted at edge N starts the leader mark at edge N+1. Requires
// UNIT >= 2 and 1 <= GAP_UNITS <= 255.
// ---------------------------------------------------------------------------
module nec_ir_transmitter
    import nec_ir_pkg::*;
#(
    parameter int CLOCK_SPEED    = 50_000_000,
    parameter int CARRIER_HZ     = 38_000,
    parameter int CARRIER_ENABLE = 1,
    parameter int GAP_UNITS      = 72
) (
    input  logic        clkIN,
    input  logic        resetIN,
    input  logic        startIN,
    input  logic        repeatIN,
    input  logic [31:0] dataIN,
    output logic        busyOUT,
    output logic        doneOUT,
    output logic        txOUT
);

    localparam int UNIT = int'((64'(CLOCK_SPEED) * 64'd9) / 64'd16000);
    localparam int UW   = $clog2(UNIT);
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT - 1);

    state_t        state, next_state;
    logic [UW-1:0] unit_cnt;
    logic [7:0]    units_left;   // units still to run after the current one
    logic [7:0]    load_val;
    logic [4:0]    bit_idx;
    logic [31:0]   shreg;
    logic          rpt_mode;
    logic          launch;       // strobe accepted, leader starts next edge
    logic          accept;
    logic          seg_end;
    logic          carrier;
    logic          tx_d;

    assign accept  = (state == IDLE) && !launch && (startIN || repeatIN);
    assign seg_end = (unit_cnt == UNIT_LAST) && (units_left == 8'd0);

    // Clearing while not in a mark puts phase 0 on the first cycle of every mark.
    nec_carrier_gen #(
        .CLOCK_SPEED (CLOCK_SPEED),
        .CARRIER_HZ  (CARRIER_HZ)
    ) u_carrier (
        .clkIN      (clkIN),
        .resetIN    (resetIN),
        .clearIN    (!is_mark(state)),
        .carrierOUT (carrier)
    );

    // load_val is the new segment length minus one, so units_left hits zero
    // in its last unit and segments chain with no idle cycle in between.
    always_comb begin
        next_state = state;
        load_val   = 8'd0;
        case (state)
            IDLE: if (launch) begin
                next_state = LEAD_MARK;
                load_val   = LEAD_MARK_U - 8'd1;
            end
            LEAD_MARK: if (seg_end) begin
                next_state = rpt_mode ? RPT_SPACE : LEAD_SPACE;
                load_val   = rpt_mode ? RPT_SPACE_U - 8'd1 : LEAD_SPACE_U - 8'd1;
            end
            LEAD_SPACE: if (seg_end) begin
                next_state = BIT_MARK;
                load_val   = BIT_MARK_U - 8'd1;
            end
            BIT_MARK: if (seg_end) begin
                next_state = BIT_SPACE;
                load_val   = shreg[31] ? ONE_SPACE_U - 8'd1 : ZERO_SPACE_U - 8'd1;
            end
            BIT_SPACE: if (seg_end) begin
                next_state = (bit_idx == 5'd0) ? STOP_MARK : BIT_MARK;
                load_val   = (bit_idx == 5'd0) ? STOP_U - 8'd1 : BIT_MARK_U - 8'd1;
            end
            RPT_SPACE: if (seg_end) begin
                next_state = STOP_MARK;
                load_val   = STOP_U - 8'd1;
            end
            STOP_MARK: if (seg_end) begin
                next_state = GAP;
                load_val   = 8'(GAP_UNITS - 1);
            end
            GAP: if (seg_end) begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // txOUT is registered from next_state so the pin changes on the same edge
    // as the state it belongs to.
    always_comb begin
        tx_d = 1'b0;
        if (is_mark(next_state)) begin
            tx_d = (CARRIER_ENABLE != 0) ? carrier : 1'b1;
        end
    end

    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            state      <= IDLE;
            unit_cnt   <= '0;
            units_left <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rpt_mode   <= 1'b0;
            launch     <= 1'b0;
            busyOUT    <= 1'b0;
            doneOUT    <= 1'b0;
            txOUT      <= 1'b0;
        end else begin
            state   <= next_state;
            launch  <= accept;
            busyOUT <= (next_state != IDLE);
            doneOUT <= (state == GAP) && seg_end;
            txOUT   <= tx_d;

            if (accept) begin
                shreg    <= dataIN;
                bit_idx  <= 5'd31;
                rpt_mode <= !startIN;
            end else if (state == BIT_SPACE && next_state == BIT_MARK) begin
                shreg   <= {shreg[30:0], 1'b0};
                bit_idx <= bit_idx - 5'd1;
            end

            if (next_state != state) begin
                unit_cnt   <= '0;
                units_left <= load_val;
            end else if (state != IDLE) begin
                if (unit_cnt == UNIT_LAST) begin
                    unit_cnt   <= '0;
                    units_left <= units_left - 8'd1;
                end else begin
                    unit_cnt <= unit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// ---------------------------------------------------------------------------
// tb_nec_ir_transmitter
// Two transmitters share all inputs: one with a flat envelope, one with the
// carrier. Each frame's expected waveform is built as a list of mark/space
// segments and compared cycle by cycle; the flat-envelope output is also
// decoded by pulse-width measurement back into a word.
// ---------------------------------------------------------------------------
module tb_nec_ir_transmitter;

    localparam int CLK_HZ  = 160_000;
    localparam int CAR_HZ  = 38_000;
    localparam int GAPU    = 4;
    localparam int UNIT    = CLK_HZ * 9 / 16000;   // 90
    localparam int CPER    = CLK_HZ / CAR_HZ;      // 4

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rpt = 1'b0;
    logic [31:0] data = 32'h0;
    logic        busy0, done0, tx0;
    logic        busy1, done1, tx1;

    int checks   = 0;
    int failures = 0;
    int exp_pos[$];   // per cycle: position inside a mark, or -1 in a space
    int runs[$];

    always #5 clk = ~clk;

    nec_ir_transmitter #(
        .CLOCK_SPEED(CLK_HZ), .CARRIER_HZ(CAR_HZ), .CARRIER_ENABLE(0), .GAP_UNITS(GAPU)
    ) dut_flat (
        .clkIN(clk), .resetIN(rst), .startIN(start), .repeatIN(rpt), .dataIN(data),
        .busyOUT(busy0), .doneOUT(done0), .txOUT(tx0)
    );

    nec_ir_transmitter #(
        .CLOCK_SPEED(CLK_HZ), .CARRIER_HZ(CAR_HZ), .CARRIER_ENABLE(1), .GAP_UNITS(GAPU)
    ) dut_car (
        .clkIN(clk), .resetIN(rst), .startIN(start), .repeatIN(rpt), .dataIN(data),
        .busyOUT(busy1), .doneOUT(done1), .txOUT(tx1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic add_seg(input bit mark, input int units);
        for (int c = 0; c < units * UNIT; c++) exp_pos.push_back(mark ? c : -1);
    endtask

    task automatic build(input bit full, input logic [31:0] w);
        exp_pos.delete();
        add_seg(1'b1, 16);
        if (full) begin
            add_seg(1'b0, 8);
            for (int b = 31; b >= 0; b--) begin
                add_seg(1'b1, 1);
                add_seg(1'b0, w[b] ? 3 : 1);
            end
        end else begin
            add_seg(1'b0, 4);
        end
        add_seg(1'b1, 1);
        add_seg(1'b0, GAPU);
    endtask

    // Every output of both instances must stay low for n cycles.
    task automatic quiet(input string tag, input int n);
        int active = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy0 || busy1 || tx0 || tx1 || done0 || done1) active++;
        end
        check(tag, active, 0);
    endtask

    // Strobe, then follow the whole frame plus two cycles. inject_at >= 0
    // pulses startIN with different data at that cycle of the frame.
    task automatic run_frame(input string tag, input bit s, input bit r,
                             input logic [31:0] w, input int inject_at);
        int len, m_tx0, m_tx1, m_ctl, dones, done_at, rl;
        bit eb, et0, et1, cur;
        logic [31:0] word;
        m_tx0 = 0; m_tx1 = 0; m_ctl = 0; dones = 0; done_at = -1; rl = 0; cur = 1'b0;
        word = 32'h0;
        build(s, w);
        len = exp_pos.size();
        runs.delete();

        @(negedge clk);
        start = s; rpt = r; data = w;
        @(negedge clk);
        start = 1'b0; rpt = 1'b0; data = ~w;
        check({tag, "_launch_busy"}, {busy0, busy1}, 2'b00);

        for (int i = 0; i < len + 2; i++) begin
            @(negedge clk);
            eb  = (i < len);
            et0 = eb ? (exp_pos[i] >= 0) : 1'b0;
            et1 = et0 && ((exp_pos[i] % CPER) < CPER / 2);
            if (tx0 !== et0) m_tx0++;
            if (tx1 !== et1) m_tx1++;
            if (busy0 !== eb || busy1 !== eb || done0 !== done1) m_ctl++;
            if (done0 === 1'b1) begin
                dones++;
                done_at = i;
            end
            if (i < len) begin
                if (i == 0) begin
                    cur = tx0; rl = 1;
                end else if (tx0 == cur) begin
                    rl++;
                end else begin
                    runs.push_back(rl); cur = tx0; rl = 1;
                end
            end
            if (i == inject_at) begin
                start = 1'b1; data = w ^ 32'h5a5a_1234;
            end else begin
                start = 1'b0;
            end
        end
        runs.push_back(rl);

        check({tag, "_tx_flat_errs"}, m_tx0, 0);
        check({tag, "_tx_car_errs"}, m_tx1, 0);
        check({tag, "_busy_errs"}, m_ctl, 0);
        check({tag, "_done_count"}, dones, 1);
        check({tag, "_done_cycle"}, done_at, len);
        if (s) begin
            // leader hi, leader lo, 32 x (mark, space), stop, gap
            check({tag, "_rx_runs"}, runs.size(), 68);
            if (runs.size() >= 68) begin
                for (int k = 0; k < 32; k++) word = {word[30:0], runs[3 + 2 * k] > 2 * UNIT};
            end
            check({tag, "_rx_word"}, word, w);
        end
        quiet({tag, "_no_followup"}, 200);
    endtask

    task automatic reset_mid_frame(input logic [31:0] w);
        int off, dones;
        off = 24 * UNIT;
        for (int b = 31; b > 21; b--) off += (1 + (w[b] ? 3 : 1)) * UNIT;
        off += UNIT / 2;   // middle of the mark of the eleventh bit sent
        @(negedge clk);
        start = 1'b1; data = w;
        @(negedge clk);
        start = 1'b0;
        repeat (off) @(negedge clk);
        check("rst_pre_busy", {busy0, busy1, tx0}, 3'b111);
        rst = 1'b1;
        #1;
        check("rst_async_outs", {tx0, busy0, done0, tx1, busy1, done1}, 6'b0);
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (done0 || done1) dones++;
        end
        rst = 1'b0;
        check("rst_no_done", dones, 0);
        quiet("rst_stays_idle", 200);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs", {busy0, done0, tx0, busy1, done1, tx1}, 6'b0);
        rst = 1'b0;

        quiet("idle_10000", 10000);
        run_frame("full_00ff906f", 1'b1, 1'b0, 32'h00ff906f, -1);
        run_frame("repeat", 1'b0, 1'b1, $urandom, -1);
        run_frame("start_while_busy", 1'b1, 1'b0, $urandom, 3000);
        run_frame("start_and_repeat", 1'b1, 1'b1, 32'hA5A5_5A5A, -1);
        reset_mid_frame($urandom);
        run_frame("after_reset", 1'b1, 1'b0, $urandom, -1);
        run_frame("loopback", 1'b1, 1'b0, 32'h00ffc23d, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
